// File: rtl/mems_dac_spi_slave.sv
// mems_dac_spi_slave: oversampled SPI responder that decodes 24-bit MEMS DAC frames into per-channel registers.
// Optional readback on miso is enabled by defining MEMS_SLAVE_READBACK_EN.
module mems_dac_spi_slave #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sck,
    input  logic                   mosi,
    input  logic                   cs_n,
    output logic                   miso,
    output logic                   frame_valid,
    output logic [23:0]            frame_word,
    output logic                   frame_err,
    output logic [16*NUM_CH-1:0]   dac_out,
    output logic                   busy
);
    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic [SYNC_STAGES:0]   prime;
    logic                   sck_q, sck_qq, mosi_q, cs_q, cs_qq, armed;
    logic                   cs_fall, cs_rise, sck_rise;
    logic [4:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [2:0]             cmd, addr;
    logic [15:0]            data;
    logic                   eval, good, accept, reject;
    logic [NUM_CH-1:0]      sel;
    logic [15:0]            in_reg [NUM_CH];
    logic [15:0]            dac_reg [NUM_CH];
    logic [15:0]            in_nxt [NUM_CH];
    logic [15:0]            dac_nxt [NUM_CH];

    // prime marks when cs_q reflects the pin rather than its reset value;
    // a frame only counts once cs_n has been seen high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            prime     <= '0;
            sck_q     <= 1'b0;
            sck_qq    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            cs_qq     <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            sck_qq    <= sck_q;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
            cs_qq     <= cs_q;
            armed     <= armed | (prime[SYNC_STAGES] & cs_q);
        end
    end

    assign cs_fall  = cs_qq & ~cs_q;
    assign cs_rise  = cs_q & ~cs_qq;
    assign sck_rise = sck_q & ~sck_qq & ~cs_q;
    assign busy     = ~cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (cs_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (sck_rise) begin
            bit_cnt   <= bit_cnt == 5'd31 ? 5'd31 : bit_cnt + 5'd1;
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_q};
        end
    end

    assign cmd    = shift_reg[21:19];
    assign addr   = shift_reg[18:16];
    assign data   = shift_reg[15:0];
    assign eval   = cs_rise & armed;
    assign good   = bit_cnt == 5'(FRAME_BITS) && !(cmd[2] && cmd[1:0] != 2'b01);
    assign accept = eval & good;
    assign reject = eval & ~good;

    // cmd 2 copies the freshly written inputs so dac_out never sees a stale value
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            sel[n]     = addr == 3'd7 || addr == 3'(n);
            in_nxt[n]  = cmd == 3'd5 ? 16'h0 :
                         (sel[n] && (cmd == 3'd0 || cmd == 3'd2 || cmd == 3'd3)) ? data : in_reg[n];
            dac_nxt[n] = cmd == 3'd5 ? 16'h0 :
                         cmd == 3'd2 ? in_nxt[n] :
                         (sel[n] && cmd == 3'd1) ? in_reg[n] :
                         (sel[n] && cmd == 3'd3) ? data : dac_reg[n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                in_reg[n]  <= '0;
                dac_reg[n] <= '0;
            end
            frame_word  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject;
            if (accept) begin
                in_reg     <= in_nxt;
                dac_reg    <= dac_nxt;
                frame_word <= shift_reg[23:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign dac_out[16*g +: 16] = dac_reg[g];
    end

`ifdef MEMS_SLAVE_READBACK_EN
    logic [2:0]  last_addr;
    logic [23:0] rb_reg;
    logic        sck_fall;

    assign sck_fall = ~sck_q & sck_qq & ~cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
            rb_reg    <= '0;
        end else begin
            if (accept)
                last_addr <= addr;
            if (cs_fall)
                rb_reg <= {8'h00, 32'(last_addr) < NUM_CH ? dac_reg[last_addr] : 16'h0};
            else if (sck_fall)
                rb_reg <= {rb_reg[22:0], 1'b0};
        end
    end

    assign miso = ~cs_q & rb_reg[23];
`else
    assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_mems_dac_spi_slave.sv
// tb_mems_dac_spi_slave: randomized SPI frames checked against a frame-level register model.
module tb_mems_dac_spi_slave;
    localparam int S    = 2;
    localparam int NCH  = 4;
    localparam int HALF = 5;

    logic              clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic              miso, frame_valid, frame_err, busy;
    logic [23:0]       frame_word;
    logic [16*NCH-1:0] dac_out;

    int checks = 0, errors = 0;
    logic [15:0] m_in [NCH];
    logic [15:0] m_dac [NCH];
    logic [23:0] m_word;
    logic [2:0]  m_addr;
    logic        settling = 1'b0;
    int          settle_cyc = 0, v_cnt = 0, e_cnt = 0, v_at = 0;

    mems_dac_spi_slave #(.FRAME_BITS(24), .SYNC_STAGES(S), .NUM_CH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso),
        .frame_valid(frame_valid), .frame_word(frame_word), .frame_err(frame_err),
        .dac_out(dac_out), .busy(busy)
    );

    always #10 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        for (int c = 0; c < NCH; c++) f[16*c +: 16] = m_dac[c];
        return f;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_in[c]  = '0;
            m_dac[c] = '0;
        end
        m_word = '0;
        m_addr = '0;
    endfunction

    function automatic void m_apply(input logic [31:0] w, input int n, output int ev, output int ee);
        logic [2:0]  cmd;
        logic [2:0]  a;
        logic [15:0] d;
        ev = 0;
        ee = 0;
        cmd = w[21:19];
        a = w[18:16];
        d = w[15:0];
        if (n != 24 || cmd == 3'd4 || cmd == 3'd6 || cmd == 3'd7) begin
            ee = 1;
            return;
        end
        ev = 1;
        m_word = w[23:0];
        m_addr = a;
        for (int c = 0; c < NCH; c++) begin
            if (cmd == 3'd5) begin
                m_in[c]  = '0;
                m_dac[c] = '0;
            end else if (a == 3'd7 || int'(a) == c) begin
                if (cmd != 3'd1) m_in[c] = d;
                if (cmd == 3'd1) m_dac[c] = m_in[c];
                if (cmd == 3'd3) m_dac[c] = d;
            end
        end
        if (cmd == 3'd2)
            for (int c = 0; c < NCH; c++) m_dac[c] = m_in[c];
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (settling) begin
                settle_cyc++;
                if (frame_valid) begin
                    v_cnt++;
                    v_at = settle_cyc;
                end
                if (frame_err) e_cnt++;
            end else begin
                check("idle_valid", 64'(frame_valid), 64'd0);
                check("idle_err", 64'(frame_err), 64'd0);
                check("dac_out", dac_out, m_flat());
                check("frame_word", 64'(frame_word), 64'(m_word));
            end
        end
    end

    task automatic shift_bits(input logic [31:0] w, input int hi, input int lo, input logic [23:0] rb, input int first);
        int idx;
        for (int i = hi; i >= lo; i--) begin
            mosi = w[i];
            repeat (HALF) @(negedge clk);
            idx = first + hi - i;
`ifdef MEMS_SLAVE_READBACK_EN
            check("miso", 64'(miso), 64'(idx < 24 ? rb[23-idx] : 1'b0));
`else
            check("miso", 64'(miso), 64'd0);
`endif
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic finish_frame(input logic [31:0] w, input int n, input int count_it);
        int ev, ee;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        ev = 0;
        ee = 0;
        if (count_it != 0) m_apply(w, n, ev, ee);
        v_cnt = 0;
        e_cnt = 0;
        settle_cyc = 0;
        settling = 1'b1;
        repeat (S + 6) @(negedge clk);
        settling = 1'b0;
        check("valid_pulses", 64'(v_cnt), 64'(ev));
        check("err_pulses", 64'(e_cnt), 64'(ee));
        if (ev != 0) check("latency", 64'(v_at), 64'(S + 2));
        check("busy_idle", 64'(busy), 64'd0);
        check("miso_idle", 64'(miso), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        logic [23:0] rb;
        @(negedge clk);
        cs_n = 1'b0;
        rb = {8'h00, int'(m_addr) < NCH ? m_dac[m_addr] : 16'h0};
        repeat (HALF) @(negedge clk);
        check("busy_active", 64'(busy), 64'd1);
        shift_bits(w, n - 1, 0, rb, 0);
        finish_frame(w, n, 1);
    endtask

    task automatic reset_mid_frame(input logic [23:0] w);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        shift_bits({8'h0, w}, 23, 12, {8'h00, int'(m_addr) < NCH ? m_dac[m_addr] : 16'h0}, 0);
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_dac", dac_out, 64'd0);
        rst_n = 1'b1;
        shift_bits({8'h0, w}, 11, 0, 24'h0, 12);
        finish_frame({8'h0, w}, 24, 0);
    endtask

    initial begin
        logic [31:0] w;
        int n;
        m_reset();
        repeat (5) @(negedge clk);
        check("rst_dac_out", dac_out, 64'd0);
        check("rst_frame_word", 64'(frame_word), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(32'h1F1234, 24);
        check("tp1_dac", dac_out, 64'h1234_1234_1234_1234);
        check("tp1_word", 64'(frame_word), 64'h1F1234);
        send_frame(32'h01ABCD, 24);
        check("tp2_hold", dac_out, 64'h1234_1234_1234_1234);
        send_frame(32'h090000, 24);
        check("tp2_load", dac_out, 64'h1234_1234_ABCD_1234);
        send_frame(32'h0F1234, 23);
        send_frame(32'h1F5678, 25);
        check("tp3_dac", dac_out, 64'h1234_1234_ABCD_1234);
        check("tp3_word", 64'(frame_word), 64'h090000);
        send_frame(32'h305555, 24);
        check("tp4_dac", dac_out, 64'h1234_1234_ABCD_1234);
        send_frame(32'h280000, 24);
        check("tp4_swreset", dac_out, 64'd0);
        send_frame(32'h1F4321, 24);
        reset_mid_frame(24'h1F7777);
        check("tp5_after_rst", dac_out, 64'd0);
        send_frame(32'h1A0F0F, 24);
        check("tp5_ch2", dac_out, 64'h0000_0F0F_0000_0000);
        send_frame(32'h18BEEF, 24);
        check("tp6_ch0", 64'(m_dac[0]), 64'hBEEF);
        send_frame(32'h11_0000, 24);
        send_frame(32'h02_2222, 24);

        for (int k = 0; k < 45; k++) begin
            w = $urandom();
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(22, 26)) : 24;
            send_frame(w, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mems_dac_spi_slave.md
Name: mems_dac_spi_slave

Overview:
- SPI responder for the 24-bit MEMS DAC frames produced by the team's SPI master (CS active-low, MOSI, SCK).
- Serves as a bench model and on-chip loopback/monitor of the MEMS driver DAC. It oversamples the SPI pins in the system clock domain, assembles frames and decodes command/address/data.
- Maintains per-channel input and output registers with DAC-style update semantics, and reports framing errors.

Parameters:
- FRAME_BITS, 24, bits per valid frame; any other count at CS deassert is a frame error.
- SYNC_STAGES, 2, synchronizer flops on sck, mosi and cs_n (legal values 2..3).
- NUM_CH, 4, number of DAC channels (addresses 0..NUM_CH-1; address 7 = all channels).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from master, asynchronous to clk, idle low.
- mosi  in  1  SPI data from master, MSB first.
- cs_n  in  1  SPI chip select, active low.
- miso  out  1  readback data; constant 0 unless the optional feature is enabled.
- frame_valid  out  1  one-clk pulse when a good frame is decoded.
- frame_word  out  24  last good frame, held until the next good frame.
- frame_err  out  1  one-clk pulse on a bad bit count or an illegal command.
- dac_out  out  16*NUM_CH  output registers; channel n occupies bits [16n+15:16n].
- busy  out  1  high while the synchronized cs_n is low.

Behaviour:
- Reset (async assert, sync deassert via the synchronizers):
  - dac_out, all input registers, frame_word, bit counter and shift register = 0.
  - frame_valid = frame_err = 0; busy = 0; miso = 0.
  - Synchronizer flops reset to sck=0, mosi=0, cs_n=1.
- Sampling (SPI mode 0):
  - mosi is shifted into the shift register on each synchronized sck rising edge while the synchronized cs_n is low.
  - The bit counter saturates at 31.
  - Minimum sck high and low time is SYNC_STAGES+2 clk cycles; faster clocks are out of spec.
- cs_n falling (synced): clear the bit counter and shift register; busy goes high on the same cycle.
- cs_n rising (synced): evaluate on that cycle.
  - Count != FRAME_BITS: frame_err pulses on the next cycle; no state changes.
  - Count == FRAME_BITS: frame_word is loaded and the frame is decoded (see decode fields below).
  - Decode outcome: frame_valid pulses on the next cycle, or frame_err pulses instead if the command is illegal.
  - Total latency from cs_n pin rise to frame_valid is SYNC_STAGES+2 clk cycles.
- Decode fields: [23:22] don't care; [21:19] cmd; [18:16] addr; [15:0] data.
- Address handling:
  - addr >= NUM_CH and != 7: the frame is legal, but writes are ignored and frame_valid still pulses.
  - addr 7 applies to all channels.
- Commands:
  - 0: write the input register(s) with data.
  - 1: copy input register(s) to dac_out (data ignored).
  - 2: write the input register(s), then copy all input registers to dac_out.
  - 3: write the input register(s) and the addressed dac_out together.
  - 5: software reset; clears every input register and dac_out to 0, regardless of addr.
  - 4, 6, 7: illegal; frame_err pulses and no state changes.
- Update ordering: for cmd 2 and cmd 3, dac_out reflects the new data in the same update cycle (write-through, no stale value).
- Simultaneous edges: a sck rise in the same clk cycle as a cs_n rise is not counted.
- A cs_n glitch shorter than the synchronizer depth is filtered only if it is absent at the sampling edge; otherwise it is treated as a short frame and raises frame_err.
- Reset mid-frame:
  - The partial frame is discarded.
  - After reset release, a frame already in progress (cs_n low) is ignored until cs_n returns high; no frame_err results from it.

Optional Feature:
- Macro: MEMS_SLAVE_READBACK_EN.
- With the macro defined:
  - On each cs_n fall, a readback register is loaded with {8'h00, dac_out of the channel addressed by the previous good frame}. If that address is >= NUM_CH, 0 is loaded instead.
  - miso is driven from this register MSB first and updates on each synced sck falling edge.
  - miso is 0 while cs_n is high.
- Without the macro: miso is tied to 0 and no readback logic exists.

Test Plan:
- Reset, then one frame 24'h1F_1234 (cmd 3, addr 7) -> frame_valid pulses once; all four dac_out channels = 16'h1234; frame_word = 24'h1F1234.
- Frame 24'h01_ABCD (cmd 0, addr 1), then 24'h09_0000 (cmd 1, addr 1) -> channel 1 dac_out stays at its prior value after frame 1 and becomes 16'hABCD after frame 2; other channels unchanged.
- A 23-bit frame, then a 25-bit frame -> two frame_err pulses; dac_out and frame_word unchanged; frame_valid never pulses.
- Frame with cmd 6 (24'h30_5555) -> frame_err pulses once; no register changes. A following 24'h28_0000 (cmd 5) -> all dac_out = 0 and frame_valid pulses.
- Assert rst_n low after 12 bits of a frame, release while cs_n is still low, then complete the frame -> no frame_valid and no frame_err. The next full frame 24'h1A_0F0F (cmd 3, addr 2) -> channel 2 = 16'h0F0F.
- With MEMS_SLAVE_READBACK_EN: write 24'h18_BEEF (cmd 3, addr 0), then send any 24-bit frame -> miso shifts out 24'h00BEEF MSB first during that frame.
